// File: rtl/mdc_input_feeder_pkg.sv
// ---------------------------------------------------------------------------
// mdc_input_feeder_pkg
// Shared constants and types for the 32-point radix-2 MDC FFT front end.
//   DW   : sample component width (two's complement)
//   N    : frame length in samples
//   HALF : N/2, depth of the input delay buffer
//   CW   : sample counter width (log2 N)
//   AW   : delay buffer address width (log2 HALF)
//   cplx_t : complex sample {re, im}, shared with the output reorder buffer
// ---------------------------------------------------------------------------
package mdc_input_feeder_pkg;

    localparam int DW   = 9;
    localparam int N    = 32;
    localparam int HALF = N / 2;
    localparam int CW   = $clog2(N);
    localparam int AW   = $clog2(HALF);

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    // Arithmetic shift right by one: sign-extended and truncated, so -3 -> -2.
    function automatic logic [DW-1:0] prescale(input logic [DW-1:0] x);
        return {x[DW-1], x[DW-1:1]};
    endfunction

endpackage

// File: rtl/mdc_input_feeder_if.sv
// ---------------------------------------------------------------------------
// mdc_input_feeder_if
// Handshake bundle of the MDC input feeder.
//   Input side : in_valid, in_ready, in_sof, in_re, in_im
//   Output side: out_valid, out_ready, outUp_re/outUp_im (x[k]),
//                outL_re/outL_im (x[k+16]), out_idx (k), frame_err
// Modports:
//   slave  : the feeder itself
//   master : the source/sink environment driving the feeder
// ---------------------------------------------------------------------------
interface mdc_input_feeder_if;
    import mdc_input_feeder_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] outUp_re;
    logic [DW-1:0] outUp_im;
    logic [DW-1:0] outL_re;
    logic [DW-1:0] outL_im;
    logic [AW-1:0] out_idx;
    logic          frame_err;

    modport slave (
        input  in_valid, in_sof, in_re, in_im, out_ready,
        output in_ready, out_valid, outUp_re, outUp_im, outL_re, outL_im,
               out_idx, frame_err
    );

    modport master (
        output in_valid, in_sof, in_re, in_im, out_ready,
        input  in_ready, out_valid, outUp_re, outUp_im, outL_re, outL_im,
               out_idx, frame_err
    );

endinterface

// File: rtl/mdc_input_feeder_delay_ram.sv
// ---------------------------------------------------------------------------
// feeder_delay_ram
// HALF-deep register file holding the first half of a frame.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data (packed complex sample)
//   raddr : read address
//   rdata : asynchronous read data
// No reset: contents are only meaningful after being written in the
// current frame.
// ---------------------------------------------------------------------------
module feeder_delay_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 18
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mdc_input_feeder.sv
// ---------------------------------------------------------------------------
// mdc_input_feeder
// Splits one natural-order complex sample stream into the dual-path pairs
// (x[k], x[k+16]) consumed by the first MDC butterfly stage.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mdc_input_feeder_if.slave (input handshake + sample, output
//         handshake + pair, pair index, frame_err pulse)
// Build option:
//   FEEDER_PRESCALE_EN : when defined, each input component is shifted
//                        right arithmetically by one before storage/output.
// ---------------------------------------------------------------------------
module mdc_input_feeder
    import mdc_input_feeder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mdc_input_feeder_if.slave     bus
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          first_half;
    logic          accept;
    logic          load;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          err_next;
    cplx_t         in_smp;
    cplx_t         rd_smp;

    logic          pair_valid;
    cplx_t         up_smp;
    cplx_t         low_smp;
    logic [AW-1:0] pair_idx;
    logic          err_pulse;

    // Counter MSB clear means we are still filling the first half.
    assign first_half   = ~cnt[CW-1];
    // Only the second half can be back-pressured by a held output pair.
    assign bus.in_ready = first_half | ~pair_valid | bus.out_ready;

    // Optional one-bit headroom prescale on the incoming sample.
    always_comb begin
`ifdef FEEDER_PRESCALE_EN
        in_smp.re = prescale(bus.in_re);
        in_smp.im = prescale(bus.in_im);
`else
        in_smp.re = bus.in_re;
        in_smp.im = bus.in_im;
`endif
    end

    // Accept decode: buffer write, output load, counter advance, resync error.
    always_comb begin
        accept   = bus.in_valid & bus.in_ready;
        wr_en    = 1'b0;
        wr_addr  = cnt[AW-1:0];
        load     = 1'b0;
        cnt_next = cnt;
        err_next = 1'b0;
        if (accept) begin
            if (bus.in_sof) begin
                // Resync: this sample is index 0 whatever the counter said.
                wr_en    = 1'b1;
                wr_addr  = {AW{1'b0}};
                cnt_next = CNT_ONE;
                err_next = (cnt != {CW{1'b0}});
            end else if (first_half) begin
                wr_en    = 1'b1;
                cnt_next = cnt + CNT_ONE;
            end else begin
                load     = 1'b1;
                cnt_next = cnt + CNT_ONE;
            end
        end else begin
            cnt_next = cnt;
        end
    end

    // Entry j written at cnt=j is read at cnt=16+j of the same frame.
    feeder_delay_ram #(
        .DEPTH (HALF),
        .AW    (AW),
        .W     (2 * DW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (in_smp),
        .raddr (cnt[AW-1:0]),
        .rdata (rd_smp)
    );

    // Counter, output pair register and resync pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= {CW{1'b0}};
            pair_valid <= 1'b0;
            up_smp     <= '0;
            low_smp    <= '0;
            pair_idx   <= {AW{1'b0}};
            err_pulse  <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            err_pulse <= err_next;
            if (load) begin
                // A new load wins over a simultaneous drain.
                pair_valid <= 1'b1;
                up_smp     <= rd_smp;
                low_smp    <= in_smp;
                pair_idx   <= cnt[AW-1:0];
            end else if (pair_valid && bus.out_ready) begin
                pair_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = pair_valid;
    assign bus.outUp_re  = up_smp.re;
    assign bus.outUp_im  = up_smp.im;
    assign bus.outL_re   = low_smp.re;
    assign bus.outL_im   = low_smp.im;
    assign bus.out_idx   = pair_idx;
    assign bus.frame_err = err_pulse;

endmodule

// File: tb/tb_mdc_input_feeder.sv
// ---------------------------------------------------------------------------
// tb_mdc_input_feeder
// Self-checking bench for mdc_input_feeder: table-driven first frame, then
// scoreboard-checked back-to-back frames, stall, resync, reset and
// extreme-value sequences.
// ---------------------------------------------------------------------------
module tb_mdc_input_feeder;
    import mdc_input_feeder_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mdc_input_feeder_if bus();

    mdc_input_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int k;
        int up_re;
        int up_im;
        int l_re;
        int l_im;
    } pair_t;

    typedef struct {
        logic sof;
        int   re;
        int   im;
        logic exp_pair;
        int   exp_k;
        int   exp_up_re;
        int   exp_up_im;
        int   exp_l_re;
        int   exp_l_im;
    } vec_t;

    pair_t sbq[$];
    vec_t  tbl[32];
    int    total     = 0;
    int    passed    = 0;
    int    ferr_seen = 0;
    int    ferr_exp  = 0;
    int    mcnt      = 0;
    int    mb_re[16];
    int    mb_im[16];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pre(input int x);
`ifdef FEEDER_PRESCALE_EN
        return x >>> 1;
`else
        return x;
`endif
    endfunction

    function automatic int sx(input logic [DW-1:0] v);
        int r;
        r = $signed(v);
        return r;
    endfunction

    // Drive one sample, wait (bounded) for acceptance, update the model.
    task automatic send(input int re, input int im, input logic sof);
        int w;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_re    = DW'(re);
        bus.in_im    = DW'(im);
        #1;
        w = 0;
        while (!bus.in_ready && w < 60) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 60) begin
            check("accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
            if (sof) begin
                if (mcnt != 0) ferr_exp++;
                mcnt = 0;
            end
            if (mcnt < 16) begin
                mb_re[mcnt] = pre(re);
                mb_im[mcnt] = pre(im);
            end else begin
                sbq.push_back('{mcnt - 16, mb_re[mcnt-16], mb_im[mcnt-16], pre(re), pre(im)});
            end
            mcnt = (mcnt + 1) % 32;
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    // Scoreboard monitor: compare every pair the sink takes.
    always begin
        pair_t p;
        @(negedge clk);
        #2;
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_pair", 1, 0);
            end else begin
                p = sbq.pop_front();
                check("sb_idx",   int'(bus.out_idx), p.k);
                check("sb_up_re", sx(bus.outUp_re), p.up_re);
                check("sb_up_im", sx(bus.outUp_im), p.up_im);
                check("sb_l_re",  sx(bus.outL_re),  p.l_re);
                check("sb_l_im",  sx(bus.outL_im),  p.l_im);
            end
        end
        if (bus.frame_err === 1'b1) ferr_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int w;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_in_ready",  int'(bus.in_ready),  1);
        check("rst_out_idx",   int'(bus.out_idx),   0);
        check("rst_up_re",     sx(bus.outUp_re),    0);
        check("rst_l_im",      sx(bus.outL_im),     0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven first frame: re = n, im = -n
        for (int n = 0; n < 32; n++) begin
            tbl[n].sof       = (n == 0);
            tbl[n].re        = n;
            tbl[n].im        = -n;
            tbl[n].exp_pair  = (n >= 16);
            tbl[n].exp_k     = n - 16;
            tbl[n].exp_up_re = pre(n - 16);
            tbl[n].exp_up_im = pre(16 - n);
            tbl[n].exp_l_re  = pre(n);
            tbl[n].exp_l_im  = pre(-n);
        end
        for (int n = 0; n < 32; n++) begin
            send(tbl[n].re, tbl[n].im, tbl[n].sof);
            @(negedge clk);
            #2;
            if (tbl[n].exp_pair) begin
                check("tbl_valid", int'(bus.out_valid), 1);
                check("tbl_idx",   int'(bus.out_idx),   tbl[n].exp_k);
                check("tbl_up_re", sx(bus.outUp_re),    tbl[n].exp_up_re);
                check("tbl_up_im", sx(bus.outUp_im),    tbl[n].exp_up_im);
                check("tbl_l_re",  sx(bus.outL_re),     tbl[n].exp_l_re);
                check("tbl_l_im",  sx(bus.outL_im),     tbl[n].exp_l_im);
            end else begin
                check("tbl_no_valid", int'(bus.out_valid), 0);
            end
        end

        // Two back-to-back frames, no gap
        for (int n = 32; n < 96; n++) begin
            send(n, -n, (n == 32));
        end

        // Stall for 5 cycles while pair k=3 is held
        fork
            begin
                for (int n = 0; n < 32; n++) begin
                    send(100 + n, -(100 + n), (n == 0));
                end
            end
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!(bus.out_valid === 1'b1 && bus.out_idx == 4'd3) && w < 200);
                if (w >= 200) begin
                    check("stall_wait", 0, 1);
                end else begin
                    bus.out_ready = 1'b0;
                    for (int i = 0; i < 5; i++) begin
                        #1;
                        check("stall_in_ready", int'(bus.in_ready),  0);
                        check("stall_valid",    int'(bus.out_valid), 1);
                        check("stall_idx",      int'(bus.out_idx),   3);
                        check("stall_up_re",    sx(bus.outUp_re),    pre(103));
                        check("stall_l_re",     sx(bus.outL_re),     pre(119));
                        @(negedge clk);
                    end
                    bus.out_ready = 1'b1;
                end
            end
        join

        // Resync: in_sof reasserted at cnt = 20
        for (int n = 0; n < 20; n++) begin
            send(150 + n, -(150 + n), (n == 0));
        end
        send(170, -170, 1'b1);
        @(negedge clk);
        #2;
        check("resync_err_pulse", int'(bus.frame_err), 1);
        @(negedge clk);
        #2;
        check("resync_err_clear", int'(bus.frame_err), 0);
        for (int n = 1; n < 32; n++) begin
            send(170 + n, -(170 + n), 1'b0);
        end

        // Reset pulsed mid-frame at cnt = 24
        for (int n = 0; n < 24; n++) begin
            send(10 + n, -(10 + n), (n == 0));
        end
        rst = 1'b1;
        #1;
        check("midrst_valid",  int'(bus.out_valid), 0);
        check("midrst_idx",    int'(bus.out_idx),   0);
        check("midrst_up_re",  sx(bus.outUp_re),    0);
        check("midrst_l_re",   sx(bus.outL_re),     0);
        check("midrst_ready",  int'(bus.in_ready),  1);
        sbq.delete();
        mcnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 32; n++) begin
            send(60 + n, -(60 + n), 1'b0);
        end

        // Extreme values: 255 / -256 / -3
        for (int n = 0; n < 32; n++) begin
            int v;
            v = (n % 3 == 0) ? 255 : ((n % 3 == 1) ? -256 : -3);
            send(v, (n % 2 == 0) ? -3 : 255, (n == 0));
        end

        repeat (3) @(negedge clk);
        #3;
        check("sb_drained", sbq.size(), 0);
        check("frame_err_count", ferr_seen, ferr_exp);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
